// File: rtl/data_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_store_pkg
//  Description : Shared types, defaults and helpers for the receive-side
//                payload store (data_store_rx and its sub-modules).
//                  rx_state_t     - receive/drain state encoding
//                  cksum_fold     - end-around-carry fold of a 17-bit sum
//                  SYMS_PER_WORD  - symbols per buffered word (defaults)
//  Revision    : 1.0 - initial release
// ============================================================================
package data_store_pkg;

  localparam int DEF_N         = 2;
  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_DEPTH     = 256;
  localparam int SYMS_PER_WORD = DEF_DATA_SIZE / DEF_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } rx_state_t;

  // Folding once is enough: two 16-bit operands sum to at most 0x1FFFE,
  // whose fold (0xFFFF) cannot carry again.
  function automatic logic [15:0] cksum_fold(input logic [16:0] sum);
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_store_rx_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_word_assembler
//  Description : Packs N-bit symbols MSB-first into W-bit words. The word is
//                presented combinationally on the cycle its last symbol
//                arrives. On i_sym_last a partial word holding at least one
//                whole byte is flushed with its low bits zero-padded.
//  Ports       : i_sym_valid/i_sym/i_sym_last - symbol stream in
//                o_word_valid/o_word           - completed word (same cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_word_assembler #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_sym_valid,
  input  logic [N-1:0] i_sym,
  input  logic         i_sym_last,
  output logic         o_word_valid,
  output logic [W-1:0] o_word
);

  localparam int c_SYMS = W / N;
  localparam int c_CW   = (c_SYMS > 1) ? $clog2(c_SYMS) : 1;

  logic [c_CW-1:0] r_cnt;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    w_sym_pos;
  logic            w_full;

  always_comb begin
    w_sym_pos = '0;
    for (int k = 0; k < c_SYMS; k++) begin
      if (r_cnt == c_CW'(k)) w_sym_pos[W-1-k*N -: N] = i_sym;
    end
    w_full       = (r_cnt == c_CW'(c_SYMS - 1));
    o_word       = r_acc | w_sym_pos;
    // A trailing fragment shorter than one byte is never flushed as a word.
    o_word_valid = i_sym_valid &&
                   (w_full || (i_sym_last && ((int'(r_cnt) + 1) * N >= 8)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_sym_valid) begin
      if (w_full || i_sym_last) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
        r_acc <= o_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
`default_nettype none
// ============================================================================
//  Module      : xilinx_true_dual_port_read_first_2_clock_ram
//  Description : Block-RAM with a read port (A) and a write port (B), each on
//                its own clock. Port A has a registered output stage, giving
//                a 2-cycle read latency.
//  Ports       : clka/ena/regcea/addra/douta - read port and output register
//                clkb/enb/web/addrb/dinb     - write port
//  Revision    : 1.0 - initial release
// ============================================================================
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 256
) (
  input  logic                         clka,
  input  logic                         ena,
  input  logic                         regcea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  output logic [RAM_WIDTH-1:0]         douta,
  input  logic                         clkb,
  input  logic                         enb,
  input  logic                         web,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dinb
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_ram_a;

  always_ff @(posedge clkb) begin
    if (enb && web) r_mem[addrb] <= dinb;
  end

  always_ff @(posedge clka) begin
    if (ena) r_ram_a <= r_mem[addra];
  end

  always_ff @(posedge clka) begin
    if (regcea) douta <= r_ram_a;
  end

endmodule
`default_nettype wire

// File: rtl/data_store_rx.sv
`default_nettype none
// ============================================================================
//  Module      : data_store_rx
//  Description : Receive-side payload store. Deserializes an N-bit MSB-first
//                symbol stream into DATA_SIZE-bit words held in BRAM, counts
//                whole bytes and accumulates the 16-bit ones-complement sum,
//                then drains the words on request.
//  Ports       : axiiv/axiid/axiil     - symbol stream in, axiil marks last
//                expected_cksum        - compared at frame end
//                read_request          - level, drains while high
//                axiov/axiod/axi_last  - drained word stream
//                data_length/data_cksum/cksum_ok/frame_done/overflow - status
//  Revision    : 1.0 - initial release
// ============================================================================
module data_store_rx
  import data_store_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axiiv,
  input  logic [N-1:0]         axiid,
  input  logic                 axiil,
  input  logic [15:0]          expected_cksum,
  input  logic                 read_request,
  output logic                 axiov,
  output logic [DATA_SIZE-1:0] axiod,
  output logic                 axi_last,
  output logic [15:0]          data_length,
  output logic [15:0]          data_cksum,
  output logic                 cksum_ok,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_IDX_W  = c_ADDR_W + 1;   // indices reach DEPTH without wrapping

  rx_state_t            r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_wr_idx, r_rd_ptr, r_out_cnt;
  logic [c_IDX_W-1:0]   w_wr_base, w_out_next;
  logic [15:0]          r_len, w_len_base, w_len_next;
  logic [2:0]           r_frac, w_frac_base;
  logic [5:0]           w_bits;
  logic [15:0]          r_sum, w_sum_base, w_sum_next;
  logic [15:0]          r_cksum;
  logic                 r_cksum_ok, r_frame_done, r_overflow;
  logic                 r_v1, r_v2, r_l1, r_l2;
  logic                 w_start, w_wr_room, w_wr_en, w_issue, w_issue_last;
  logic                 w_word_valid, w_half_valid;
  logic [DATA_SIZE-1:0] w_word, w_douta;
  logic [15:0]          w_half;

  rx_word_assembler #(.N(N), .W(DATA_SIZE)) u_word_asm (
    .clk(clk), .rst(rst), .i_sym_valid(axiiv), .i_sym(axiid), .i_sym_last(axiil),
    .o_word_valid(w_word_valid), .o_word(w_word)
  );

  rx_word_assembler #(.N(N), .W(16)) u_half_asm (
    .clk(clk), .rst(rst), .i_sym_valid(axiiv), .i_sym(axiid), .i_sym_last(axiil),
    .o_word_valid(w_half_valid), .o_word(w_half)
  );

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(DATA_SIZE), .RAM_DEPTH(DEPTH)
  ) u_ram (
    .clka(clk), .ena(1'b1), .regcea(1'b1), .addra(r_rd_ptr[c_ADDR_W-1:0]), .douta(w_douta),
    .clkb(clk), .enb(1'b1), .web(w_wr_en), .addrb(w_wr_base[c_ADDR_W-1:0]), .dinb(w_word)
  );

  // Any symbol arriving outside FILL opens a new frame; the per-frame
  // counters then restart from zero on this very symbol.
  always_comb begin
    w_start      = axiiv && (r_state != FILL);
    w_wr_base    = w_start ? '0 : r_wr_idx;
    w_wr_room    = (w_wr_base < c_IDX_W'(DEPTH));
    w_wr_en      = w_word_valid && w_wr_room;
    w_len_base   = w_start ? '0 : r_len;
    w_frac_base  = w_start ? '0 : r_frac;
    w_bits       = {3'd0, w_frac_base} + 6'(N);
    w_len_next   = w_len_base + 16'(w_bits[5:3]);
    w_sum_base   = w_start ? '0 : r_sum;
    w_sum_next   = w_half_valid ? cksum_fold({1'b0, w_sum_base} + {1'b0, w_half})
                                : w_sum_base;
    w_issue      = read_request && !axiiv && ((r_state == DONE) || (r_state == DRAIN))
                   && (r_rd_ptr < r_wr_idx);
    w_issue_last = w_issue && ((r_rd_ptr + c_IDX_W'(1)) == r_wr_idx);
    w_out_next   = r_out_cnt + c_IDX_W'(r_v2);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DONE:    if (w_issue) w_state_nxt = DRAIN;
      DRAIN:   if (r_v2 && r_l2) w_state_nxt = DONE;
      default: w_state_nxt = r_state;
    endcase
    if (axiiv) w_state_nxt = axiil ? DONE : FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_idx     <= '0;
      r_len        <= '0;
      r_frac       <= '0;
      r_sum        <= '0;
      r_cksum      <= '0;
      r_cksum_ok   <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_ptr     <= '0;
      r_out_cnt    <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_l1         <= 1'b0;
      r_l2         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= axiiv && axiil;
      if (axiiv) begin
        r_wr_idx   <= w_wr_base + (w_wr_en ? c_IDX_W'(1) : c_IDX_W'(0));
        r_overflow <= (w_start ? 1'b0 : r_overflow) | (w_word_valid && !w_wr_room);
        r_len      <= w_len_next;
        r_frac     <= w_bits[2:0];
        r_sum      <= w_sum_next;
        if (axiil) begin
          r_cksum    <= ~w_sum_next;
          r_cksum_ok <= (~w_sum_next == expected_cksum);
        end else if (w_start) begin
          r_cksum    <= '0;
          r_cksum_ok <= 1'b0;
        end
      end
      if (w_start) begin
        r_rd_ptr  <= '0;
        r_out_cnt <= '0;
        r_v1      <= 1'b0;
        r_v2      <= 1'b0;
        r_l1      <= 1'b0;
        r_l2      <= 1'b0;
      end else begin
        r_v1      <= w_issue;
        r_l1      <= w_issue_last;
        // Dropping read_request kills words still inside the BRAM pipeline
        // and rewinds the read pointer to the first word not yet presented.
        r_v2      <= r_v1 && read_request;
        r_l2      <= r_l1 && read_request;
        r_out_cnt <= w_out_next;
        if (!read_request) r_rd_ptr <= w_out_next;
        else if (w_issue)  r_rd_ptr <= r_rd_ptr + c_IDX_W'(1);
      end
    end
  end

  assign axiov       = r_v2;
  assign axi_last    = r_v2 && r_l2;
  assign axiod       = r_v2 ? w_douta : '0;
  assign data_length = r_len;
  assign data_cksum  = r_cksum;
  assign cksum_ok    = r_cksum_ok;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_data_store_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_store_rx
//  Description : Self-checking bench for data_store_rx (N=2, DATA_SIZE=16,
//                DEPTH=4). Frames come from a vector table; drained words are
//                checked against a scoreboard queue filled from the same table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_store_rx;

  localparam int N  = 2;
  localparam int DS = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          axiiv = 1'b0;
  logic [N-1:0]  axiid = '0;
  logic          axiil = 1'b0;
  logic [15:0]   expected_cksum = '0;
  logic          read_request = 1'b0;
  logic          axiov;
  logic [DS-1:0] axiod;
  logic          axi_last;
  logic [15:0]   data_length;
  logic [15:0]   data_cksum;
  logic          cksum_ok;
  logic          frame_done;
  logic          overflow;

  always #5 clk = ~clk;

  data_store_rx #(.N(N), .DATA_SIZE(DS), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiil(axiil),
    .expected_cksum(expected_cksum), .read_request(read_request),
    .axiov(axiov), .axiod(axiod), .axi_last(axi_last),
    .data_length(data_length), .data_cksum(data_cksum), .cksum_ok(cksum_ok),
    .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct {
    int          nbytes;
    logic [95:0] data;    // byte 0 in [95:88]
    logic [15:0] ck_in;
    logic [15:0] len;
    logic [15:0] ck;
    logic        ok;
    logic        ov;
  } vec_t;

  typedef struct packed {
    logic [15:0] word;
    logic        last;
  } sb_t;

  vec_t frames [6];
  sb_t  sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input logic [95:0] d, input int i);
    return d[95-8*i -: 8];
  endfunction

  function automatic int stored_words(input int v);
    int w;
    w = (frames[v].nbytes + 1) / 2;
    return (w > DP) ? DP : w;
  endfunction

  // Drained-word monitor.
  always @(negedge clk) begin
    if (!rst && axiov) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", axiod, $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("drain_word", 32'(axiod), 32'(e.word));
        chk("drain_last", 32'(axi_last), 32'(e.last));
      end
    end
  end

  task automatic send_syms(input int v, input int first, input int stop);
    int nsym;
    logic [7:0] b;
    nsym = frames[v].nbytes * 4;
    for (int s = first; s < stop; s++) begin
      b              = byte_at(frames[v].data, s / 4);
      axiiv          = 1'b1;
      axiid          = b[7-2*(s%4) -: 2];
      axiil          = (s == nsym - 1);
      expected_cksum = frames[v].ck_in;
      step();
    end
    axiiv = 1'b0;
    axiil = 1'b0;
  endtask

  task automatic check_frame(input int v);
    int nw;
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("data_length", 32'(data_length), 32'(frames[v].len));
    chk("data_cksum", 32'(data_cksum), 32'(frames[v].ck));
    chk("cksum_ok", 32'(cksum_ok), 32'(frames[v].ok));
    chk("overflow", 32'(overflow), 32'(frames[v].ov));
    nw = stored_words(v);
    for (int w = 0; w < nw; w++)
      sb.push_back({byte_at(frames[v].data, 2*w), byte_at(frames[v].data, 2*w+1), w == nw - 1});
    step();
    chk("frame_done_pulse", 32'(frame_done), 32'd0);
    chk("length_held", 32'(data_length), 32'(frames[v].len));
  endtask

  task automatic drain(input int exp_words);
    int lat, cnt;
    read_request = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!axiov && lat < 8);
    if (exp_words == 0) chk("empty_drain_valid", 32'(axiov), 32'd0);
    else                chk("drain_latency", 32'(lat), 32'd2);
    cnt = 0;
    while (axiov && cnt < 16) begin cnt++; step(); end
    chk("drain_count", 32'(cnt), 32'(exp_words));
    read_request = 1'b0;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat, cnt;
    frames[0] = '{4,  {32'h45000030, 64'h0},         16'hBACF, 16'd4,  16'hBACF, 1'b1, 1'b0};
    frames[1] = '{3,  {24'h123456, 72'h0},           16'h0000, 16'd3,  16'h97CB, 1'b0, 1'b0};
    frames[2] = '{4,  {32'hFFFF0001, 64'h0},         16'h0000, 16'd4,  16'hFFFE, 1'b0, 1'b0};
    frames[3] = '{6,  {48'h010203040506, 48'h0},     16'hF6F3, 16'd6,  16'hF6F3, 1'b1, 1'b0};
    frames[4] = '{12, 96'h000102030405060708090A0B, 16'hE1DB, 16'd12, 16'hE1DB, 1'b1, 1'b1};
    frames[5] = frames[0];

    // Reset state.
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_axiov", 32'(axiov), 32'd0);
    chk("rst_length", 32'(data_length), 32'd0);
    chk("rst_cksum", 32'(data_cksum), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step();

    // Table: send, check status, drain everything.
    for (int v = 0; v < 6; v++) begin
      send_syms(v, 0, frames[v].nbytes * 4);
      check_frame(v);
      drain(stored_words(v));
    end

    // Pause mid-drain for one cycle, then resume.
    send_syms(3, 0, 24);
    check_frame(3);
    read_request = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!axiov && lat < 8);
    chk("pause_first_latency", 32'(lat), 32'd2);
    read_request = 1'b0;
    step();
    chk("pause_gap0", 32'(axiov), 32'd0);
    read_request = 1'b1;
    step();
    chk("pause_gap1", 32'(axiov), 32'd0);
    step();
    cnt = 0;
    while (axiov && cnt < 16) begin cnt++; step(); end
    chk("resume_count", 32'(cnt), 32'd2);
    read_request = 1'b0;
    chk("resume_sb_empty", 32'(sb.size()), 32'd0);

    // New symbol during DRAIN aborts the drain and starts a frame.
    send_syms(3, 0, 24);
    check_frame(3);
    read_request = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!axiov && lat < 8);
    chk("abort_first_latency", 32'(lat), 32'd2);
    axiiv = 1'b1;
    axiid = 2'b00;                 // first dibit of 0x12
    axiil = 1'b0;
    expected_cksum = frames[1].ck_in;
    step();
    chk("abort_axiov", 32'(axiov), 32'd0);
    read_request = 1'b0;
    sb.delete();
    send_syms(1, 1, 12);
    check_frame(1);
    drain(stored_words(1));

    // Asynchronous reset in the middle of an overflowing frame.
    send_syms(4, 0, 44);
    chk("pre_rst_overflow", 32'(overflow), 32'd1);
    chk("pre_rst_length", 32'(data_length), 32'd11);
    rst = 1'b1;
    #1;
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    chk("async_rst_length", 32'(data_length), 32'd0);
    chk("async_rst_axiov", 32'(axiov), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    send_syms(0, 0, 16);
    check_frame(0);
    drain(stored_words(0));

    // Zero-word frame: a single dibit carrying axiil.
    axiiv = 1'b1;
    axiid = 2'b10;
    axiil = 1'b1;
    step();
    axiiv = 1'b0;
    axiil = 1'b0;
    chk("zero_frame_done", 32'(frame_done), 32'd1);
    chk("zero_frame_length", 32'(data_length), 32'd0);
    step();
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
